// File: rtl/rr_arbiter.sv
// Round-robin arbiter: rotating-mask winner selection over two LSB-first
// priority encoders, registered one-hot grant held until release, request
// drop, or an optional hold limit.
//
// The owner's end-of-transaction pulse is named release_pulse because
// "release" is a reserved word in SystemVerilog.

// Priority encoder: reports the index of the lowest (LSB) or highest (MSB)
// set bit of vector, plus whether any bit is set at all.
module priority_encoder #(
  parameter int    WIDTH = 4,
  parameter string ORDER = "LSB"
) (
  input  logic [WIDTH-1:0]         vector,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     valid
);

  localparam int IW = $clog2(WIDTH);

  // Scan so that the preferred end of the vector is written last and wins.
  always_comb begin
    index = '0;
    valid = |vector;
    if (ORDER == "MSB") begin
      for (int i = 0; i < WIDTH; i++)
        if (vector[i]) index = IW'(i);
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--)
        if (vector[i]) index = IW'(i);
    end
  end

endmodule

// State table:
//   state | meaning
//   IDLE  | no grant outstanding; any request is granted at the next edge
//   BUSY  | grant held by grant_id until release, request drop or hold limit
module rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         requests,
  input  logic                     release_pulse,
  output logic [WIDTH-1:0]         grant,
  output logic [$clog2(WIDTH)-1:0] grant_id,
  output logic                     grant_valid,
  output logic                     timeout
);

  localparam int IW = $clog2(WIDTH);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state, state_next;
  logic [IW-1:0]    last, last_next;
  logic [WIDTH-1:0] grant_next;
  logic [IW-1:0]    grant_id_next;
  logic             timeout_next;
  logic [WIDTH-1:0] cand, mask, masked;
  logic [IW-1:0]    idx_masked, idx_all, winner;
  logic             valid_masked, valid_all;
  logic             owner_active, limit_hit, terminate, load;

  // Candidates: everyone in IDLE, everyone except the outgoing owner in BUSY.
  // Bits 0..last are masked so the search starts just above the last winner.
  always_comb begin
    cand = (state == IDLE) ? requests : (requests & ~grant);
    for (int i = 0; i < WIDTH; i++)
      mask[i] = (i > int'(last));
    masked = cand & mask;
  end

  priority_encoder #(WIDTH, "LSB") u_pe_masked (
    .vector (masked),
    .index  (idx_masked),
    .valid  (valid_masked)
  );

  priority_encoder #(WIDTH, "LSB") u_pe_all (
    .vector (cand),
    .index  (idx_all),
    .valid  (valid_all)
  );

  assign winner       = valid_masked ? idx_masked : idx_all;
  assign owner_active = requests[grant_id];
  assign terminate    = (state == BUSY) && (release_pulse || !owner_active || limit_hit);
  assign grant_valid  = |grant;

  // Hold-limit counter exists only when a limit is configured.
  generate
    if (MAX_HOLD > 0) begin : g_hold
      localparam int HW = $clog2(MAX_HOLD + 1);
      logic [HW-1:0] hold_count;

      assign limit_hit = (hold_count == HW'(MAX_HOLD));

      // Cycles of continuous ownership by the current grant holder.
      always_ff @(posedge clock or posedge reset) begin
        if (reset)
          hold_count <= '0;
        else if (load)
          hold_count <= HW'(1);
        else if (terminate)
          hold_count <= '0;
        else if (state == BUSY)
          hold_count <= hold_count + HW'(1);
      end
    end else begin : g_no_hold
      assign limit_hit = 1'b0;
    end
  endgenerate

  // Next-state, next-grant and timeout decode.
  always_comb begin
    state_next    = state;
    grant_next    = grant;
    grant_id_next = grant_id;
    last_next     = last;
    timeout_next  = 1'b0;
    load          = 1'b0;
    case (state)
      IDLE: begin
        if (valid_all) begin
          grant_next         = '0;
          grant_next[winner] = 1'b1;
          grant_id_next      = winner;
          last_next          = winner;
          load               = 1'b1;
          state_next         = BUSY;
        end
      end
      BUSY: begin
        if (terminate) begin
          timeout_next = limit_hit && !release_pulse && owner_active;
          if (valid_all) begin
            grant_next         = '0;
            grant_next[winner] = 1'b1;
            grant_id_next      = winner;
            last_next          = winner;
            load               = 1'b1;
          end else begin
            grant_next    = '0;
            grant_id_next = '0;
            state_next    = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and output registers; reset drops any grant immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      grant_id <= '0;
      last     <= IW'(WIDTH - 1);
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      grant_id <= grant_id_next;
      last     <= last_next;
      timeout  <= timeout_next;
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Scoreboard bench for rr_arbiter: two instances (no hold limit, MAX_HOLD=3)
// share stimulus; each step queues the grant expected after the next edge.
module tb_rr_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] requests = '0;
  logic       release_pulse = 1'b0;

  logic [3:0] grant_a, grant_h;
  logic [1:0] id_a, id_h;
  logic       valid_a, valid_h, timeout_a, timeout_h;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;   // 0: no-limit instance, 1: hold-limit instance
    logic [3:0] grant;
    logic [1:0] id;
    logic       timeout;
  } exp_t;

  exp_t sb[$];

  rr_arbiter #(.WIDTH(4), .MAX_HOLD(0)) u_dut_a (
    .clock         (clock),
    .reset         (reset),
    .requests      (requests),
    .release_pulse (release_pulse),
    .grant         (grant_a),
    .grant_id      (id_a),
    .grant_valid   (valid_a),
    .timeout       (timeout_a)
  );

  rr_arbiter #(.WIDTH(4), .MAX_HOLD(3)) u_dut_h (
    .clock         (clock),
    .reset         (reset),
    .requests      (requests),
    .release_pulse (release_pulse),
    .grant         (grant_h),
    .grant_id      (id_h),
    .grant_valid   (valid_h),
    .timeout       (timeout_h)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected result, then compare
  // just after the edge that produces it.
  task automatic step(input bit sel, input logic [3:0] req, input logic rel,
                      input logic [3:0] eg, input logic [1:0] eid, input logic eto,
                      input string tag);
    exp_t e;
    requests      = req;
    release_pulse = rel;
    sb.push_back('{sel: sel, grant: eg, id: eid, timeout: eto});
    @(posedge clock);
    #1;
    e = sb.pop_front();
    if (e.sel) begin
      check({tag, ".grant"},   32'(grant_h),   32'(e.grant));
      check({tag, ".id"},      32'(id_h),      32'(e.id));
      check({tag, ".valid"},   32'(valid_h),   32'(|e.grant));
      check({tag, ".timeout"}, 32'(timeout_h), 32'(e.timeout));
    end else begin
      check({tag, ".grant"},   32'(grant_a),   32'(e.grant));
      check({tag, ".id"},      32'(id_a),      32'(e.id));
      check({tag, ".valid"},   32'(valid_a),   32'(|e.grant));
      check({tag, ".timeout"}, 32'(timeout_a), 32'(e.timeout));
    end
  endtask

  task automatic do_reset();
    requests      = '0;
    release_pulse = 1'b0;
    #2 reset = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    @(posedge clock);
    #1;
    check("rst.grant_a",   32'(grant_a),   32'h0);
    check("rst.id_a",      32'(id_a),      32'h0);
    check("rst.valid_a",   32'(valid_a),   32'h0);
    check("rst.timeout_h", 32'(timeout_h), 32'h0);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;

    // Basic grant, handoff and wrap-around
    step(0, 4'b1010, 0, 4'b0010, 2'd1, 0, "basic.c1");
    step(0, 4'b1010, 0, 4'b0010, 2'd1, 0, "basic.c2");
    step(0, 4'b1010, 0, 4'b0010, 2'd1, 0, "basic.c3");
    step(0, 4'b1010, 1, 4'b1000, 2'd3, 0, "basic.c4");
    step(0, 4'b1010, 0, 4'b1000, 2'd3, 0, "basic.c5");
    step(0, 4'b1010, 1, 4'b0010, 2'd1, 0, "basic.wrap");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "basic.drop");

    // Rotation with everyone requesting
    do_reset();
    step(0, 4'b1111, 0, 4'b0001, 2'd0, 0, "rot.0");
    step(0, 4'b1111, 1, 4'b0010, 2'd1, 0, "rot.1");
    step(0, 4'b1111, 1, 4'b0100, 2'd2, 0, "rot.2");
    step(0, 4'b1111, 1, 4'b1000, 2'd3, 0, "rot.3");
    step(0, 4'b1111, 1, 4'b0001, 2'd0, 0, "rot.4");

    // Request drop: owner 0 drops, 2 takes over, then 2 drops
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "drop.to2");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "drop.idle");
    step(0, 4'b0001, 0, 4'b0001, 2'd0, 0, "drop.regrant");

    // Release together with request drop: one termination
    step(0, 4'b0010, 1, 4'b0010, 2'd1, 0, "corner.reldrop");
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "corner.reldrop_idle");
    // Release while idle has no effect
    step(0, 4'b0000, 1, 4'b0000, 2'd0, 0, "corner.idle_rel");
    step(0, 4'b0000, 0, 4'b0000, 2'd0, 0, "corner.idle_rel2");
    // Sole requester releases: one idle cycle, then re-grant
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "corner.sole");
    step(0, 4'b0100, 1, 4'b0000, 2'd0, 0, "corner.sole_idle");
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "corner.sole_regrant");

    // Hold limit 3 on the second instance
    do_reset();
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 0, "hold.c1");
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 0, "hold.c2");
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 0, "hold.c3");
    step(1, 4'b0101, 0, 4'b0100, 2'd2, 1, "hold.c4");
    step(1, 4'b0101, 0, 4'b0100, 2'd2, 0, "hold.c5");
    step(1, 4'b0101, 0, 4'b0100, 2'd2, 0, "hold.c6");
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 1, "hold.c7");
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 0, "hold.c8");
    step(1, 4'b0101, 0, 4'b0001, 2'd0, 0, "hold.c9");
    // Release coinciding with the limit is not a pure timeout
    step(1, 4'b0101, 1, 4'b0100, 2'd2, 0, "hold.rel_at_limit");

    // Asynchronous reset in mid-grant
    do_reset();
    step(0, 4'b0100, 0, 4'b0100, 2'd2, 0, "areset.setup");
    #2 reset = 1'b1;
    #1;
    check("areset.grant", 32'(grant_a), 32'h0);
    check("areset.id",    32'(id_a),    32'h0);
    check("areset.valid", 32'(valid_a), 32'h0);
    requests = 4'b1111;
    #1 reset = 1'b0;
    step(0, 4'b1111, 0, 4'b0001, 2'd0, 0, "areset.regrant");

    check("sb.empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter that shares one resource among `WIDTH` requesters. It uses LSB-priority `priority_encoder` instances over a rotating mask and holds a registered one-hot grant until the owner releases it, the owner drops its request, or an optional hold limit expires. It sits in front of shared ports such as the memory interface, the bus, or the cache fill path, where several clients compete for the same resource.

## Interface
- `WIDTH`, default 4: number of requesters; must be at least 2.
- `MAX_HOLD`, default 0: maximum number of grant cycles before a forced handoff; 0 disables the limit.
- `clock`  input  1: rising-edge clock.
- `reset`  input  1: asynchronous, active-high reset.
- `requests`  input  WIDTH: request vector; bit i set means requester i wants the resource.
- `release`  input  1: single-cycle pulse from the current owner marking the end of its transaction.
- `grant`  output  WIDTH: registered one-hot grant.
- `grant_id`  output  log2(WIDTH): binary index of the granted requester.
- `grant_valid`  output  1: equals |grant.
- `timeout`  output  1: one-cycle pulse indicating the previous grant ended by `MAX_HOLD`.

## Operation
- **State:**
  - `state` is IDLE or BUSY.
  - `last` holds the index of the most recent winner.
  - `hold_count` has width log2(MAX_HOLD+1) and is absent when MAX_HOLD=0.
- **Winner selection (combinational), given a candidate vector `cand`:**
  - `masked` = `cand` with bits 0..`last` cleared.
  - If `masked` is non-zero, the winner is the lowest set bit of `masked`. Otherwise the winner is the lowest set bit of `cand`.
  - These are two `priority_encoder #(WIDTH,"LSB")` instances; the valid outputs select between them.
- **IDLE:**
  - `cand` = `requests`.
  - If `cand` is non-zero, at the next edge:
    - `grant` <= onehot(winner) and `grant_id` <= winner;
    - `last` <= winner;
    - `hold_count` <= 1;
    - state becomes BUSY.
  - `release` is ignored in IDLE.
- **BUSY termination:** the grant terminates this cycle if any of the following holds:
  - `release` = 1;
  - `requests[grant_id]` = 0;
  - MAX_HOLD ≠ 0 and `hold_count` == MAX_HOLD.
  
  Simultaneous causes count as a single termination.
- **BUSY, no termination:** grant is held and `hold_count` increments.
- **BUSY, termination:**
  - `cand` = `requests & ~grant`.
  - If `cand` is non-zero, the grant switches directly to the winner at the next edge. `last` and `hold_count` are updated as in IDLE, and the state stays BUSY.
  - Otherwise, at the next edge `grant` <= 0, `grant_id` <= 0, and the state becomes IDLE. The terminated owner may be re-granted from IDLE one cycle later.
- **`timeout`:** registered. It is 1 for exactly the cycle after a termination whose only cause was the hold limit; otherwise 0.
- **Reset (asynchronous, immediate):**
  - `grant` = 0, `grant_id` = 0, `grant_valid` = 0, `timeout` = 0;
  - state = IDLE;
  - `last` = WIDTH-1, so requester 0 has highest priority first;
  - `hold_count` = 0.
  
  A reset in mid-grant drops the grant immediately, with no release handshake.

## Timing
- Latency from request to grant is 1 cycle: a request sampled at edge N produces a grant visible after edge N.
- A handoff between owners has zero dead cycles: the termination cycle is followed immediately by the new grant.
- Termination with no other requester costs 1 idle cycle before any new grant.
- `grant`, `grant_id` and `grant_valid` change only at clock edges or on reset; there is no combinational path from `requests` or `release` to these outputs.
- With hold limit M, the maximum continuous ownership is M cycles.
- Fairness: with all requesters continuously requesting, each one is granted once every WIDTH grants.

## Test plan
All scenarios use WIDTH=4 and MAX_HOLD=0 unless stated otherwise.

1. **Basic grant and handoff:** hold `requests`=1010 from cycle 0.
   - Expect `grant`=0010 and `grant_id`=1 from cycle 1.
   - Pulse `release` in cycle 3: expect `grant`=1000 and `grant_id`=3 in cycle 4.
   - Pulse `release` in cycle 5: expect `grant`=0010 in cycle 6 (wrap-around).
2. **Rotation:** hold `requests`=1111 and pulse `release` every grant cycle.
   - Expect `grant` = 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with `grant_valid`=1 throughout.
3. **Request drop:** owner 2 holds `grant`=0100, then `requests` goes to 0000.
   - Expect `grant`=0000 and `grant_valid`=0 in the next cycle.
   - Drive `requests`=0001 in that same cycle: expect `grant`=0001 one cycle later.
4. **Hold limit:** MAX_HOLD=3, hold `requests`=0101, never assert `release`.
   - Expect `grant`=0001 in cycles 1–3.
   - In cycle 4 expect `grant`=0100 with `timeout`=1.
   - In cycle 5 expect `timeout`=0 with `grant` still 0100.
   - In cycle 7 expect `grant`=0001 and `timeout`=1.
5. **Asynchronous reset in mid-grant:** with `grant`=0100, assert `reset` between clock edges.
   - Expect `grant`=0, `grant_id`=0 and `grant_valid`=0 immediately.
   - Deassert `reset` with `requests`=1111: expect `grant`=0001 one cycle later.
6. **Corner cases:**
   - `release` together with a request drop in the same cycle behaves as a single termination.
   - `release` pulsed in IDLE with `requests`=0000: `grant` stays 0.
   - Sole requester releases: expect an IDLE cycle, then a re-grant of the same requester.
